psum_acc_relu: RTL and testbench

- Downstream consumer of the 4-MAC wrapper stage.
- Takes one signed partial sum per cycle and accumulates a group of len psums, e.g. the partial sums of successive 4-element K-tiles.
- Applies optional ReLU and signed saturation, then presents the result on a one-deep valid/ready output register that feeds the output SRAM writer.

---
 rtl/psum_acc_relu_pkg.sv | 18 +
 rtl/psum_acc_relu_sat_add.sv | 34 +++
 rtl/psum_acc_relu.sv | 135 +++++++++++++
 tb/tb_psum_acc_relu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_relu_pkg.sv
// Shared types and saturation bounds for the partial-sum accumulator.
// The bounds are functions of the accumulator width so every instance width can use them.
package psum_acc_relu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    function automatic longint acc_max(input int bw);
        return (longint'(1) <<< (bw - 1)) - longint'(1);
    endfunction

    function automatic longint acc_min(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

endpackage

// File: rtl/psum_acc_relu_sat_add.sv
// Combinational signed add of two W-bit operands with clamping to the W-bit range.
// ovf_o flags that the true sum did not fit and a clamp was applied.
module sat_add
    import psum_acc_relu_pkg::*;
#(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                ovf_o
);

    localparam logic signed [W:0] MAX_X = (W+1)'(acc_max(W));
    localparam logic signed [W:0] MIN_X = (W+1)'(acc_min(W));

    logic signed [W:0] raw;

    // One guard bit is enough: the sum of two W-bit values always fits in W+1 bits.
    assign raw = {a_i[W-1], a_i} + {b_i[W-1], b_i};

    always_comb begin
        sum_o = raw[W-1:0];
        ovf_o = 1'b0;
        if (raw > MAX_X) begin
            sum_o = MAX_X[W-1:0];
            ovf_o = 1'b1;
        end else if (raw < MIN_X) begin
            sum_o = MIN_X[W-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/psum_acc_relu.sv
// Accumulates groups of signed partial sums, then saturates, optionally applies ReLU,
// and holds the group result in a one-deep valid/ready output register.
module psum_acc_relu
    import psum_acc_relu_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20,
    parameter int cnt_bw  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [psum_bw-1:0]  in_psum,
    input  logic        [cnt_bw-1:0]   len,
    input  logic                       relu_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [acc_bw-1:0]   out_data,
    output logic                       out_sat,
    output logic                       busy
);

    state_e                    state_q, state_d;
    logic signed [acc_bw-1:0]  acc_q, acc_d;
    logic        [cnt_bw-1:0]  count_q, count_d;
    logic                      sat_q, sat_d;
    logic        [cnt_bw-1:0]  len_q, len_d;
    logic                      relu_q, relu_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [acc_bw-1:0]  out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic                      in_xfer;
    logic                      out_xfer;
    logic signed [acc_bw-1:0]  psum_ext;
    logic signed [acc_bw-1:0]  acc_op;
    logic signed [acc_bw-1:0]  sum;
    logic                      ovf;
    logic        [cnt_bw-1:0]  eff_len;
    logic        [cnt_bw-1:0]  count_inc;
    logic                      relu_sel;
    logic                      last;
    logic signed [acc_bw-1:0]  result;

    // A stalled result blocks every input, since the output register is the only buffer.
    assign in_ready  = !(out_valid_q && !out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;

    assign psum_ext  = acc_bw'(in_psum);
    assign acc_op    = (state_q == IDLE) ? '0 : acc_q;

    sat_add #(.W(acc_bw)) u_sat_add (
        .a_i   (acc_op),
        .b_i   (psum_ext),
        .sum_o (sum),
        .ovf_o (ovf)
    );

    // In IDLE the group parameters come straight from the inputs; count_q is 0 there,
    // so count_inc == eff_len covers both the single-psum and multi-psum finish.
    assign eff_len   = (state_q == IDLE) ? ((len == '0) ? cnt_bw'(1) : len) : len_q;
    assign relu_sel  = (state_q == IDLE) ? relu_en : relu_q;
    assign count_inc = count_q + cnt_bw'(1);
    assign last      = (count_inc == eff_len);
    assign result    = (relu_sel && sum[acc_bw-1]) ? '0 : sum;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        len_d       = len_q;
        relu_d      = relu_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (in_xfer) begin
            if (state_q == IDLE) begin
                len_d  = eff_len;
                relu_d = relu_en;
            end
            if (last) begin
                out_valid_d = 1'b1;
                out_data_d  = result;
                out_sat_d   = sat_q | ovf;
                acc_d       = '0;
                count_d     = '0;
                sat_d       = 1'b0;
                state_d     = IDLE;
            end else begin
                acc_d       = sum;
                count_d     = count_inc;
                sat_d       = sat_q | ovf;
                state_d     = ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            len_q       <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            len_q       <= len_d;
            relu_q      <= relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (state_q == ACC);

endmodule

// File: tb/tb_psum_acc_relu.sv
// Drives a 20-bit and a 16-bit accumulator instance with identical traffic and checks
// both against a group-level model every cycle, plus literal results for known groups.
module tb_psum_acc_relu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_psum;
    logic [3:0]  len;
    logic        relu_en;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
    logic [19:0] out_data_a;
    logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
    logic [15:0] out_data_b;

    int total = 0;
    int bad   = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    psum_acc_relu #(.psum_bw(16), .acc_bw(20), .cnt_bw(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_psum(in_psum), .len(len), .relu_en(relu_en), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a), .busy(busy_a)
    );

    psum_acc_relu #(.psum_bw(16), .acc_bw(16), .cnt_bw(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_psum(in_psum), .len(len), .relu_en(relu_en), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b), .busy(busy_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint msk(input longint v, input int bw);
        return v & ((longint'(1) << bw) - 1);
    endfunction

    // Reference: fold the whole group with per-step clamping, then ReLU.
    function automatic void fold(input longint ps[$], input int bw, input bit relu,
                                 output longint d, output bit s);
        longint mx, mn, acc;
        mx  = (longint'(1) << (bw - 1)) - 1;
        mn  = -mx - 1;
        acc = 0;
        s   = 1'b0;
        foreach (ps[i]) begin
            acc = acc + ps[i];
            if (acc > mx) begin acc = mx; s = 1'b1; end
            else if (acc < mn) begin acc = mn; s = 1'b1; end
        end
        d = (relu && acc < 0) ? 0 : acc;
    endfunction

    // Model state: open group contents and the expected output register.
    longint m_ps[$];
    int     m_len;
    bit     m_relu, m_open, m_valid;
    longint m_data20, m_data16;
    bit     m_sat20, m_sat16;
    bit     m_fin, m_in_rdy, m_out_xfer;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ps.delete();
            m_len = 0; m_relu = 0; m_open = 0; m_valid = 0;
            m_data20 = 0; m_data16 = 0; m_sat20 = 0; m_sat16 = 0;
        end else begin
            m_fin      = 1'b0;
            m_in_rdy   = !(m_valid && !out_ready);
            m_out_xfer = m_valid && out_ready;
            if (in_valid && m_in_rdy) begin
                if (!m_open) begin
                    m_len  = (len == 0) ? 1 : int'(len);
                    m_relu = relu_en;
                end
                m_ps.push_back(longint'($signed(in_psum)));
                if (m_ps.size() == m_len) begin
                    m_fin = 1'b1;
                    fold(m_ps, 20, m_relu, m_data20, m_sat20);
                    fold(m_ps, 16, m_relu, m_data16, m_sat16);
                    m_ps.delete();
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end
            if (m_fin) m_valid = 1'b1;
            else if (m_out_xfer) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready_a",  in_ready_a,  !(m_valid && !out_ready));
        chk("in_ready_b",  in_ready_b,  !(m_valid && !out_ready));
        chk("out_valid_a", out_valid_a, m_valid);
        chk("out_valid_b", out_valid_b, m_valid);
        chk("busy_a",      busy_a,      m_open);
        chk("busy_b",      busy_b,      m_open);
        chk("out_data_a",  out_data_a,  msk(m_data20, 20));
        chk("out_data_b",  out_data_b,  msk(m_data16, 16));
        chk("out_sat_a",   out_sat_a,   m_sat20);
        chk("out_sat_b",   out_sat_b,   m_sat16);
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #2 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at a falling edge; returns at the falling edge after the psum is accepted.
    task automatic send(input int p, input int l, input bit r);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_psum  = 16'(p);
        len      = 4'(l);
        relu_en  = r;
        while (!in_ready_a && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("send_timeout", guard, 0);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #2 out_ready = v;
        @(negedge clk);
    endtask

    initial begin
        int p;
        reset = 1'b0; in_valid = 1'b0; in_psum = '0; len = '0; relu_en = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_data",  out_data_a,  0);
        chk("rst_busy",  busy_a,      0);
        reset = 1'b1;
        @(negedge clk);

        // Basic group of four
        send(10, 4, 0);
        chk("g4_busy", busy_a, 1);
        send(-3, 4, 0);
        send(7, 4, 0);
        send(2, 4, 0);
        chk("g4_valid", out_valid_a, 1);
        chk("g4_data",  out_data_a,  16);
        chk("g4_sat",   out_sat_a,   0);
        idle();
        chk("g4_pulse", out_valid_a, 0);

        // ReLU on and off
        send(-20, 2, 1);
        send(5, 2, 1);
        chk("relu1_data", out_data_a, 0);
        chk("relu1_sat",  out_sat_a,  0);
        send(-20, 2, 0);
        send(5, 2, 0);
        chk("relu0_data", out_data_a, 20'hFFFF1);

        // Saturation in the 16-bit instance only
        send(32767, 3, 0);
        send(1, 3, 0);
        send(-1, 3, 0);
        chk("sat16_data", out_data_b, 32766);
        chk("sat16_sat",  out_sat_b,  1);
        chk("sat20_data", out_data_a, 32767);
        chk("sat20_sat",  out_sat_a,  0);
        idle();

        // Backpressure with single-psum groups
        set_ready(0);
        send(5, 1, 0);
        chk("bp_valid", out_valid_a, 1);
        chk("bp_ready", in_ready_a,  0);
        in_valid = 1'b1; in_psum = 16'd6; len = 4'd1;
        @(negedge clk);
        chk("bp_hold_ready", in_ready_a, 0);
        chk("bp_hold_data",  out_data_a, 5);
        set_ready(1);
        chk("bp_release_ready", in_ready_a, 1);
        @(negedge clk);
        chk("bp_next_valid", out_valid_a, 1);
        chk("bp_next_data",  out_data_a,  6);
        idle();
        chk("bp_drained", out_valid_a, 0);

        // len=0 behaves as len=1
        send(7, 0, 0);
        chk("len0_data", out_data_a, 7);
        chk("len0_busy", busy_a, 0);
        send(-3, 0, 0);
        chk("len0_neg", out_data_a, 20'hFFFFD);
        idle();

        // Asynchronous reset in the middle of a group
        send(1, 4, 0);
        send(2, 4, 0);
        idle();
        chk("mid_busy", busy_a, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_busy",  busy_a,      0);
        chk("async_data",  out_data_a,  0);
        chk("async_valid", out_valid_a, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(1, 4, 0);
        chk("post_rst_data", out_data_a, 4);
        idle();

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) idle();
            case ($urandom_range(0, 5))
                0:       p = 32767;
                1:       p = -32768;
                default: p = int'($urandom_range(0, 65535)) - 32768;
            endcase
            send(p, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        @(negedge clk);
        set_ready(1);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
